// File: rtl/arm_pkg.sv
// Shared encodings for the multicycle ARM control path: state enum, mux select codes, op field values.
package arm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/arm_mc_ctrl_outdec.sv
// Combinational state -> mux select / write strobe decoder for the multicycle control FSM.
module arm_mc_ctrl_outdec
  import arm_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output logic       irwrite,
  output logic       nextpc,
  output logic       regw,
  output logic       memw,
  output logic       branch,
  output logic       adrsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       aluop
);

  always_comb begin
    irwrite   = 1'b0;
    nextpc    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = SRCB_RM;
    resultsrc = RES_ALUOUT;
    aluop     = 1'b0;
    case (state)
      S_FETCH: begin
        irwrite   = mem_ready;
        nextpc    = mem_ready;
        alusrca   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
      end
      S_DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
      end
      S_MEMADR: alusrcb = SRCB_IMM;
      S_MEMRD:  adrsrc  = 1'b1;
      S_MEMWB: begin
        regw      = 1'b1;
        resultsrc = RES_RDATA;
      end
      // Write strobe is held through wait cycles; memory commits on mem_ready.
      S_MEMWR: begin
        memw   = 1'b1;
        adrsrc = 1'b1;
      end
      S_EXECR: aluop = 1'b1;
      S_EXECI: begin
        alusrcb = SRCB_IMM;
        aluop   = 1'b1;
      end
      S_ALUWB: regw = 1'b1;
      S_BRANCH: begin
        branch    = 1'b1;
        alusrcb   = SRCB_IMM;
        resultsrc = RES_ALU;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arm_mc_ctrl_fsm.sv
// Main multicycle ARM control FSM: state register, next-state logic, reset gating of strobes.
// Optional debug ports dbg_state / dbg_undef are enabled by defining ARM_MC_CTRL_DBG_EN.
module arm_mc_ctrl_fsm
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       irwrite,
  output logic       nextpc,
  output logic       regw,
  output logic       memw,
  output logic       branch,
  output logic       adrsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       aluop
`ifdef ARM_MC_CTRL_DBG_EN
  ,
  output logic [3:0] dbg_state,
  output logic       dbg_undef
`endif
);

  state_t state, next_state, dec_state;
  logic   irwrite_raw, nextpc_raw, regw_raw, memw_raw, branch_raw;
  logic   funct_unused;

  assign funct_unused = ^funct[4:1];

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_MEM:  next_state = S_MEMADR;
          OP_DP:   next_state = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECR:  next_state = S_ALUWB;
      S_EXECI:  next_state = S_ALUWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // While reset is held the selects already present the fetch setup.
  assign dec_state = reset ? S_FETCH : state;

  arm_mc_ctrl_outdec u_outdec (
    .state     (dec_state),
    .mem_ready (mem_ready),
    .irwrite   (irwrite_raw),
    .nextpc    (nextpc_raw),
    .regw      (regw_raw),
    .memw      (memw_raw),
    .branch    (branch_raw),
    .adrsrc    (adrsrc),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .resultsrc (resultsrc),
    .aluop     (aluop)
  );

  assign irwrite = irwrite_raw & ~reset;
  assign nextpc  = nextpc_raw  & ~reset;
  assign regw    = regw_raw    & ~reset;
  assign memw    = memw_raw    & ~reset;
  assign branch  = branch_raw  & ~reset;

`ifdef ARM_MC_CTRL_DBG_EN
  assign dbg_state = dec_state;
  assign dbg_undef = ~reset & (state == S_DECODE) & (op == 2'b11);
`endif

endmodule

// File: tb/tb_arm_mc_ctrl_fsm.sv
// Directed table-driven bench for arm_mc_ctrl_fsm plus cycles-per-instruction sequences.
module tb_arm_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset, mem_ready;
  logic [1:0] op;
  logic [5:0] funct;
  logic       irwrite, nextpc, regw, memw, branch, adrsrc, alusrca, aluop;
  logic [1:0] alusrcb, resultsrc;
`ifdef ARM_MC_CTRL_DBG_EN
  logic [3:0] dbg_state;
  logic       dbg_undef;
`endif

  always #5 clk = ~clk;

  arm_mc_ctrl_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .mem_ready (mem_ready),
    .irwrite   (irwrite),
    .nextpc    (nextpc),
    .regw      (regw),
    .memw      (memw),
    .branch    (branch),
    .adrsrc    (adrsrc),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .resultsrc (resultsrc),
    .aluop     (aluop)
`ifdef ARM_MC_CTRL_DBG_EN
    ,
    .dbg_state (dbg_state),
    .dbg_undef (dbg_undef)
`endif
  );

  // Output vector: irwrite nextpc regw memw branch adrsrc alusrca alusrcb[1:0] resultsrc[1:0] aluop
  localparam logic [11:0] E_FGO  = 12'b1_1_0_0_0_0_1_10_10_0;
  localparam logic [11:0] E_FST  = 12'b0_0_0_0_0_0_1_10_10_0;
  localparam logic [11:0] E_DEC  = 12'b0_0_0_0_0_0_1_10_10_0;
  localparam logic [11:0] E_MADR = 12'b0_0_0_0_0_0_0_01_00_0;
  localparam logic [11:0] E_MRD  = 12'b0_0_0_0_0_1_0_00_00_0;
  localparam logic [11:0] E_MWB  = 12'b0_0_1_0_0_0_0_00_01_0;
  localparam logic [11:0] E_MWR  = 12'b0_0_0_1_0_1_0_00_00_0;
  localparam logic [11:0] E_EXR  = 12'b0_0_0_0_0_0_0_00_00_1;
  localparam logic [11:0] E_EXI  = 12'b0_0_0_0_0_0_0_01_00_1;
  localparam logic [11:0] E_AWB  = 12'b0_0_1_0_0_0_0_00_00_0;
  localparam logic [11:0] E_BR   = 12'b0_0_0_0_1_0_0_01_10_0;

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        rdy;
    logic [11:0] exp;
    logic [3:0]  st;
    logic        undef;
  } vec_t;

  vec_t tbl[$];
  int   compared = 0;
  int   mismatched = 0;

  function automatic logic [11:0] outs();
    return {irwrite, nextpc, regw, memw, branch, adrsrc, alusrca, alusrcb, resultsrc, aluop};
  endfunction

  task automatic add(input string nm, input logic r, input logic [1:0] o, input logic [5:0] f,
                     input logic rd, input logic [11:0] e, input logic [3:0] s, input logic u);
    vec_t v;
    v.name = nm; v.rst = r; v.op = o; v.funct = f; v.rdy = rd;
    v.exp = e; v.st = s; v.undef = u;
    tbl.push_back(v);
  endtask

  task automatic cpi(input logic [1:0] o, input logic [5:0] f, input int exp_n, input string nm);
    int n;
    bit seen;
    reset = 1'b0; op = o; funct = f; mem_ready = 1'b1;
    n = 0; seen = 0;
    @(posedge clk); n = 1;
    while (!seen && n < 20) begin
      @(negedge clk); #1;
      if (irwrite) seen = 1;
      else begin
        @(posedge clk); n++;
      end
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL cpi_%s: no return to fetch within %0d cycles, required %0d", nm, n, exp_n);
    end else if (n != exp_n) begin
      mismatched++;
      $display("FAIL cpi_%s: took %0d cycles, required %0d", nm, n, exp_n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 2'b00; funct = 6'b0;

    add("rst0",        1, 2'b00, 6'b000000, 1, E_FST,  4'd0, 0);
    add("rst1",        1, 2'b00, 6'b000000, 1, E_FST,  4'd0, 0);
    add("dp_fetch",    0, 2'b00, 6'b000000, 1, E_FGO,  4'd0, 0);
    add("dp_decode",   0, 2'b00, 6'b000000, 1, E_DEC,  4'd1, 0);
    add("dp_execr",    0, 2'b00, 6'b000000, 1, E_EXR,  4'd6, 0);
    add("dp_aluwb",    0, 2'b00, 6'b000000, 1, E_AWB,  4'd8, 0);
    add("ldr_fetch",   0, 2'b01, 6'b011001, 1, E_FGO,  4'd0, 0);
    add("ldr_decode",  0, 2'b01, 6'b011001, 1, E_DEC,  4'd1, 0);
    add("ldr_memadr",  0, 2'b01, 6'b011001, 1, E_MADR, 4'd2, 0);
    add("ldr_memrd",   0, 2'b01, 6'b011001, 1, E_MRD,  4'd3, 0);
    add("ldr_memwb",   0, 2'b01, 6'b011001, 1, E_MWB,  4'd4, 0);
    add("str_fetch",   0, 2'b01, 6'b011000, 1, E_FGO,  4'd0, 0);
    add("str_decode",  0, 2'b01, 6'b011000, 1, E_DEC,  4'd1, 0);
    add("str_memadr",  0, 2'b01, 6'b011000, 0, E_MADR, 4'd2, 0);
    add("str_wait0",   0, 2'b01, 6'b011000, 0, E_MWR,  4'd5, 0);
    add("str_wait1",   0, 2'b01, 6'b011000, 0, E_MWR,  4'd5, 0);
    add("str_wait2",   0, 2'b01, 6'b011000, 0, E_MWR,  4'd5, 0);
    add("str_commit",  0, 2'b01, 6'b011000, 1, E_MWR,  4'd5, 0);
    add("fetch_stall", 0, 2'b01, 6'b011000, 0, E_FST,  4'd0, 0);
    add("b_fetch",     0, 2'b10, 6'b000000, 1, E_FGO,  4'd0, 0);
    add("b_decode",    0, 2'b10, 6'b000000, 1, E_DEC,  4'd1, 0);
    add("b_branch",    0, 2'b10, 6'b000000, 1, E_BR,   4'd9, 0);
    add("dpi_fetch",   0, 2'b00, 6'b100000, 1, E_FGO,  4'd0, 0);
    add("dpi_decode",  0, 2'b00, 6'b100000, 1, E_DEC,  4'd1, 0);
    add("dpi_execi",   0, 2'b00, 6'b100000, 1, E_EXI,  4'd7, 0);
    add("dpi_aluwb",   0, 2'b00, 6'b100000, 1, E_AWB,  4'd8, 0);
    add("und_fetch",   0, 2'b11, 6'b111111, 1, E_FGO,  4'd0, 0);
    add("und_decode",  0, 2'b11, 6'b111111, 1, E_DEC,  4'd1, 1);
    add("ldr2_fetch",  0, 2'b01, 6'b000001, 1, E_FGO,  4'd0, 0);
    add("ldr2_decode", 0, 2'b01, 6'b000001, 1, E_DEC,  4'd1, 0);
    add("ldr2_memadr", 0, 2'b01, 6'b000001, 0, E_MADR, 4'd2, 0);
    add("ldr2_stall",  0, 2'b01, 6'b000001, 0, E_MRD,  4'd3, 0);
    add("ldr2_memrd",  0, 2'b01, 6'b000001, 1, E_MRD,  4'd3, 0);
    add("rst_in_wb",   1, 2'b01, 6'b000001, 1, E_FST,  4'd0, 0);
    add("after_rst",   0, 2'b01, 6'b000000, 1, E_FGO,  4'd0, 0);
    add("str2_decode", 0, 2'b01, 6'b000000, 1, E_DEC,  4'd1, 0);
    add("str2_memadr", 0, 2'b01, 6'b000000, 0, E_MADR, 4'd2, 0);
    add("rst_in_wr",   1, 2'b01, 6'b000000, 0, E_FST,  4'd0, 0);
    add("after_rst2",  0, 2'b01, 6'b000000, 0, E_FST,  4'd0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; op = tbl[i].op; funct = tbl[i].funct; mem_ready = tbl[i].rdy;
      #1;
      compared++;
      if (outs() !== tbl[i].exp) begin
        mismatched++;
        $display("FAIL %s: outputs=%b expected=%b", tbl[i].name, outs(), tbl[i].exp);
      end
`ifdef ARM_MC_CTRL_DBG_EN
      compared++;
      if (dbg_state !== tbl[i].st || dbg_undef !== tbl[i].undef) begin
        mismatched++;
        $display("FAIL %s_dbg: state=%0d undef=%b expected state=%0d undef=%b",
                 tbl[i].name, dbg_state, dbg_undef, tbl[i].st, tbl[i].undef);
      end
`endif
    end

    cpi(2'b00, 6'b000000, 4, "dp");
    cpi(2'b01, 6'b000001, 5, "ldr");
    cpi(2'b01, 6'b000000, 4, "str");
    cpi(2'b10, 6'b000000, 3, "b");
    cpi(2'b11, 6'b000000, 2, "undef");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
